rx_char_fifo: RTL

//  Receive buffer directly downstream of character_recovery: captures each recovered

---
 rtl/uart_lite_pkg.sv | 18 +
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/rx_char_fifo.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_lite_pkg.sv
// Shared receive/transmit types for the UART-lite path.
// Holds the stored FIFO entry layout and the pointer-width helper.
package uart_lite_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef struct packed {
        logic                      parity_err;
        logic                      frame_err;
        logic [UART_DATA_BITS-1:0] chr;
    } rx_entry_t;

    // One extra pointer bit distinguishes full from empty.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// Storage is not reset; the pointers in the owning FIFO define what is valid.
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_char_fifo.sv
// Receive character FIFO: captures recovered characters with their error flags
// and presents them first-word-fall-through, with a sticky overrun flag.
module rx_char_fifo
    import uart_lite_pkg::*;
#(
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int DEPTH        = 16,
    parameter bit KEEP_ERRORED = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [DATA_BITS-1:0]     char_i,
    input  logic                     valid_i,
    input  logic                     frame_err_i,
    input  logic                     parity_err_i,
    output logic [DATA_BITS-1:0]     data_o,
    output logic                     frame_err_o,
    output logic                     parity_err_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o,
    input  logic                     overrun_clr_i
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int EW = DATA_BITS + 2;

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          ovr_q, ovr_d;
    logic          push_req, do_push, do_pop, full, empty;
    logic [EW-1:0] rdata;

    assign push_req = valid_i | (KEEP_ERRORED & (frame_err_i | parity_err_i));
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop   = !empty && ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push_req && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovr_d = ovr_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_req && !do_push) begin
            ovr_d = 1'b1;
        end else if (overrun_clr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovr_q <= ovr_d;
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (do_push),
        .waddr_i (wr_q[AW-1:0]),
        .wdata_i ({parity_err_i, frame_err_i, char_i}),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (rdata)
    );

    assign {parity_err_o, frame_err_o, data_o} = empty ? '0 : rdata;
    assign valid_o   = !empty;
    assign count_o   = wr_q - rd_q;
    assign overrun_o = ovr_q;

endmodule
